permute_controller: RTL and testbench



---
 rtl/permute_controller_pkg.sv | 18 +
 rtl/permute_controller_slice_counter.sv | 45 ++++
 rtl/permute_controller.sv | 124 ++++++++++++
 tb/tb_permute_controller.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/permute_controller_pkg.sv
// Shared encoder-wide definitions for the permute stage controller:
// state encoding and default sizing constants.
package permute_controller_pkg;

  localparam int SLICE_W            = 25;
  localparam int NUM_SLICES_DEFAULT = 64;
  localparam int ADDR_W_DEFAULT     = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_LOAD_IN  = 3'd2,
    ST_LOAD_OUT = 3'd3,
    ST_WRITE    = 3'd4,
    ST_DONE     = 3'd5
  } perm_state_e;

endpackage

// File: rtl/permute_controller_slice_counter.sv
// slice_counter: ADDR_W-bit slice index with synchronous clear, increment
// enable and a terminal-count flag at NUM_SLICES-1. Increments are ignored
// once the terminal count is reached, so the index never leaves 0..NUM_SLICES-1.
module slice_counter
  import permute_controller_pkg::*;
#(
  parameter int NUM_SLICES = NUM_SLICES_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SLICES - 1);

  logic [ADDR_W-1:0] cnt_d;
  logic [ADDR_W-1:0] cnt_q;

  // Next count: clear wins over increment; saturate at the last slice.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LAST)) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/permute_controller.sv
// permute_controller: sequences the permute datapath (input register,
// permuter, output register) over NUM_SLICES memory slices, four cycles per
// slice: READ, LOAD_IN, LOAD_OUT, WRITE, then a one-cycle DONE pulse.
// Optional macro PERMUTE_ABORT_EN adds an 'abort' input that returns any
// active run to IDLE without a done pulse.
module permute_controller
  import permute_controller_pkg::*;
#(
  parameter int NUM_SLICES = NUM_SLICES_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef PERMUTE_ABORT_EN
  input  logic              abort,
`endif
  output logic              ready,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              input_ld,
  output logic              output_ld,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr
);

  perm_state_e       state_q;
  perm_state_e       state_d;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_tc;
  logic              abort_req;

`ifdef PERMUTE_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  slice_counter #(
    .NUM_SLICES (NUM_SLICES),
    .ADDR_W     (ADDR_W)
  ) u_slice_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  // Next-state and counter control; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          cnt_clr = 1'b1;
        end
      end
      ST_READ:     state_d = ST_LOAD_IN;
      ST_LOAD_IN:  state_d = ST_LOAD_OUT;
      ST_LOAD_OUT: state_d = ST_WRITE;
      ST_WRITE: begin
        if (cnt_tc) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    if (abort_req && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
  end

  // State register with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode: each strobe belongs to exactly one state.
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    input_ld  = 1'b0;
    output_ld = 1'b0;
    mem_wr_en = 1'b0;
    case (state_q)
      ST_IDLE:     ready     = 1'b1;
      ST_READ:     mem_rd_en = 1'b1;
      ST_LOAD_IN:  input_ld  = 1'b1;
      ST_LOAD_OUT: output_ld = 1'b1;
      ST_WRITE:    mem_wr_en = 1'b1;
      ST_DONE:     done      = 1'b1;
      default:     ready     = 1'b0;
    endcase
  end

  assign mem_rd_addr = cnt;
  assign mem_wr_addr = cnt;

endmodule

// File: tb/tb_permute_controller.sv
// Testbench for permute_controller: a 64-slice instance driving a small
// behavioural memory/permuter model, plus a 1-slice instance for the
// minimum-size sequence. Abort scenarios build with PERMUTE_ABORT_EN.
module tb_permute_controller;
  import permute_controller_pkg::*;

  localparam int N  = 64;
  localparam int AW = 6;
  localparam int LOGSZ = 1024;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_s;
`ifdef PERMUTE_ABORT_EN
  logic abort;
  logic abort_s;
`endif

  logic          ready, done, mem_rd_en, input_ld, output_ld, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic          ready_s, done_s, rd_en_s, in_ld_s, out_ld_s, wr_en_s;
  logic [0:0]    rd_addr_s, wr_addr_s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural datapath and activity logs.
  logic [SLICE_W-1:0] src [N];
  logic [SLICE_W-1:0] dest [N];
  logic [SLICE_W-1:0] rd_data, in_reg, out_reg;
  int rd_count = 0, wr_count = 0, done_count = 0, overlap_count = 0;
  int done_cyc = 0;
  int rd_cyc_log  [LOGSZ];
  int wr_cyc_log  [LOGSZ];
  int wr_addr_log [LOGSZ];

  permute_controller #(.NUM_SLICES(N), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef PERMUTE_ABORT_EN
    .abort       (abort),
`endif
    .ready       (ready),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .input_ld    (input_ld),
    .output_ld   (output_ld),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr)
  );

  permute_controller #(.NUM_SLICES(1), .ADDR_W(1)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s),
`ifdef PERMUTE_ABORT_EN
    .abort       (abort_s),
`endif
    .ready       (ready_s),
    .done        (done_s),
    .mem_rd_en   (rd_en_s),
    .mem_rd_addr (rd_addr_s),
    .input_ld    (in_ld_s),
    .output_ld   (out_ld_s),
    .mem_wr_en   (wr_en_s),
    .mem_wr_addr (wr_addr_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference permutation: bit reversal of a slice.
  function automatic logic [SLICE_W-1:0] permute(input logic [SLICE_W-1:0] x);
    logic [SLICE_W-1:0] r;
    for (int b = 0; b < SLICE_W; b++) r[b] = x[SLICE_W-1-b];
    return r;
  endfunction

  // Memory/datapath model and logging, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      dest[mem_wr_addr] = out_reg;
      if (wr_count < LOGSZ) begin
        wr_cyc_log[wr_count]  = cyc;
        wr_addr_log[wr_count] = int'(mem_wr_addr);
      end
      wr_count++;
    end
    if (output_ld === 1'b1) out_reg = permute(in_reg);
    if (input_ld === 1'b1) in_reg = rd_data;
    if (mem_rd_en === 1'b1) begin
      rd_data = src[mem_rd_addr];
      if (rd_count < LOGSZ) rd_cyc_log[rd_count] = cyc;
      rd_count++;
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    if ($countones({mem_rd_en, input_ld, output_ld, mem_wr_en, done}) > 1) overlap_count++;
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
`ifdef PERMUTE_ABORT_EN
    abort = 1'b0; abort_s = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, done, mem_rd_en, input_ld, output_ld, mem_wr_en} !== 6'b100000) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc %0d: got %b want 100000", i,
                 {ready, done, mem_rd_en, input_ld, output_ld, mem_wr_en});
      end
      checks++;
      if (mem_rd_addr !== 6'd0 || mem_wr_addr !== 6'd0) begin
        errors++;
        $display("[TB] FAIL reset_addr: got rd=%0d wr=%0d want 0", mem_rd_addr, mem_wr_addr);
      end
    end
    checks++;
    if ({ready_s, done_s, rd_en_s, in_ld_s, out_ld_s, wr_en_s} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_small: got %b want 100000",
               {ready_s, done_s, rd_en_s, in_ld_s, out_ld_s, wr_en_s});
    end
  endtask

  task automatic test_full_run();
    int s, base_rd, base_wr, base_done;
    bit got;
    for (int i = 0; i < N; i++) src[i] = SLICE_W'(i * 32'h0001357);
    @(negedge clk); #1;
    base_rd = rd_count; base_wr = wr_count; base_done = done_count; s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 6'd0 || ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_read: got rd_en=%b addr=%0d ready=%b want 1/0/0",
               mem_rd_en, mem_rd_addr, ready);
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL full_done_timeout: got no done want done within 400 cycles");
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_single_pulse: got done=%b ready=%b want 0/1", done, ready);
    end
    checks++;
    if (done_cyc - (s + 1) !== 4 * N) begin
      errors++;
      $display("[TB] FAIL done_latency: got %0d want %0d", done_cyc - (s + 1), 4 * N);
    end
    checks++;
    if (done_count - base_done !== 1) begin
      errors++;
      $display("[TB] FAIL done_count: got %0d want 1", done_count - base_done);
    end
    checks++;
    if (rd_count - base_rd !== N || wr_count - base_wr !== N) begin
      errors++;
      $display("[TB] FAIL access_count: got rd=%0d wr=%0d want %0d", rd_count - base_rd,
               wr_count - base_wr, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (wr_addr_log[base_wr + i] !== i) begin
        errors++;
        $display("[TB] FAIL write_order[%0d]: got addr %0d want %0d", i, wr_addr_log[base_wr + i], i);
      end
      checks++;
      if (wr_cyc_log[base_wr + i] - rd_cyc_log[base_rd + i] !== 3) begin
        errors++;
        $display("[TB] FAIL rd_to_wr[%0d]: got %0d want 3", i,
                 wr_cyc_log[base_wr + i] - rd_cyc_log[base_rd + i]);
      end
      checks++;
      if (dest[i] !== permute(SLICE_W'(i * 32'h0001357))) begin
        errors++;
        $display("[TB] FAIL dest[%0d]: got %h want %h", i, dest[i], permute(SLICE_W'(i * 32'h0001357)));
      end
    end
  endtask

  task automatic test_start_held();
    int base_rd, base_done;
    bit got;
    @(negedge clk); #1;
    base_rd = rd_count; base_done = done_count;
    start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL held_done_timeout: got no done want done within 400 cycles");
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_idle_gap: got ready=%b rd_en=%b want 1/0", ready, mem_rd_en);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL held_restart: got rd_en=%b addr=%0d want 1/0", mem_rd_en, mem_rd_addr);
    end
    #1;
    checks++;
    if (rd_count - base_rd !== N + 1 || done_count - base_done !== 1) begin
      errors++;
      $display("[TB] FAIL held_one_run: got reads=%0d dones=%0d want %0d/1",
               rd_count - base_rd, done_count - base_done, N + 1);
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL held_second_timeout: got no done want done within 400 cycles");
    end
    @(negedge clk); #1;
    checks++;
    if (overlap_count !== 0) begin
      errors++;
      $display("[TB] FAIL strobe_overlap: got %0d cycles want 0", overlap_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int w0, d0;
    bit got;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (mem_wr_en === 1'b1 && mem_wr_addr === 6'd10) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL wr10_timeout: got no write at 10 want one within 100 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, done, mem_rd_en, input_ld, output_ld, mem_wr_en} !== 6'b100000 ||
        mem_rd_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_run: got %b addr=%0d want 100000 addr=0",
               {ready, done, mem_rd_en, input_ld, output_ld, mem_wr_en}, mem_rd_addr);
    end
    #1;
    w0 = wr_count; d0 = done_count;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (wr_count !== w0 || done_count !== d0) begin
      errors++;
      $display("[TB] FAIL rst_no_activity: got writes=%0d dones=%0d want 0/0",
               wr_count - w0, done_count - d0);
    end
    checks++;
    if (wr_addr_log[wr_count - 1] !== 10) begin
      errors++;
      $display("[TB] FAIL rst_last_write: got addr %0d want 10", wr_addr_log[wr_count - 1]);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rst_restart: got rd_en=%b addr=%0d want 1/0", mem_rd_en, mem_rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_slice();
    logic [5:0] exp;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      if (j > 1) @(negedge clk);
      exp = 6'b100000 >> (j - 1);
      checks++;
      if ({rd_en_s, in_ld_s, out_ld_s, wr_en_s, done_s, ready_s} !== exp) begin
        errors++;
        $display("[TB] FAIL single_seq cycle %0d: got %b want %b", j,
                 {rd_en_s, in_ld_s, out_ld_s, wr_en_s, done_s, ready_s}, exp);
      end
    end
    checks++;
    if (rd_addr_s !== 1'b0 || wr_addr_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_addr: got rd=%0d wr=%0d want 0", rd_addr_s, wr_addr_s);
    end
  endtask

`ifdef PERMUTE_ABORT_EN
  task automatic test_abort();
    int w0, d0;
    bit got;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (output_ld === 1'b1 && mem_rd_addr === 6'd3) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL abort_wait_timeout: got no LOAD_OUT of slice 3 want one within 40 cycles");
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({ready, done, mem_rd_en, input_ld, output_ld, mem_wr_en} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL abort_to_idle: got %b want 100000",
               {ready, done, mem_rd_en, input_ld, output_ld, mem_wr_en});
    end
    #1;
    w0 = wr_count; d0 = done_count;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (wr_count !== w0 || done_count !== d0 || wr_addr_log[wr_count - 1] !== 2) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got writes=%0d dones=%0d last=%0d want 0/0/2",
               wr_count - w0, done_count - d0, wr_addr_log[wr_count - 1]);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL abort_in_idle: got rd_en=%b addr=%0d want 1/0", mem_rd_en, mem_rd_addr);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_in_read: got ready=%b want 1", ready);
    end
  endtask
`endif

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_run();
    test_start_held();
    test_reset_mid_run();
    test_single_slice();
`ifdef PERMUTE_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
